// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control FSM for the 8-bit processor; sequences PC, AR, IR, ACC and memory handshake.
// Optional build macro PCSEQ_ILLEGAL_TRAP_EN: opcodes 0x7-0xF trap into HALT and raise illegal_op.
//
// state   | meaning
// --------+--------------------------------------------------------------
// RST     | post-reset idle cycle, all outputs low
// FETCH   | read opcode byte at PC into IR, bump PC
// DECODE  | classify IR opcode, choose operand fetch / halt / next fetch
// OPERAND | read operand address byte at PC into AR, bump PC
// EXEC    | LDA/ADD/STA memory access at AR, or JMP/JZ PC reload
// HALT    | parked until reset
module pc_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_rdy,
  input  logic [7:0] ir_in,
  input  logic       zero_flag,
  output logic       inc_pr,
  output logic       load_ar_2_pr,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       load_ir,
  output logic       load_ar,
  output logic       load_acc,
  output logic       add_acc,
  output logic       halted
`ifdef PCSEQ_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  typedef enum logic [2:0] {
    S_RST     = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_OPERAND = 3'd3,
    S_EXEC    = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_HLT = 4'h6;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] w_op;
  logic       w_unused_lo;

  assign w_op        = ir_in[7:4];
  assign w_unused_lo = ^ir_in[3:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RST;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    inc_pr       = 1'b0;
    load_ar_2_pr = 1'b0;
    addr_sel     = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    load_ir      = 1'b0;
    load_ar      = 1'b0;
    load_acc     = 1'b0;
    add_acc      = 1'b0;
    halted       = 1'b0;

    case (r_state)
      S_RST: begin
        w_next_state = S_FETCH;
      end

      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          load_ir      = 1'b1;
          inc_pr       = 1'b1;
          w_next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        case (w_op)
          OP_NOP:                                w_next_state = S_FETCH;
          OP_LDA, OP_STA, OP_ADD, OP_JMP, OP_JZ: w_next_state = S_OPERAND;
          OP_HLT:                                w_next_state = S_HALT;
`ifdef PCSEQ_ILLEGAL_TRAP_EN
          default:                               w_next_state = S_HALT;
`else
          default:                               w_next_state = S_FETCH;
`endif
        endcase
      end

      S_OPERAND: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          load_ar      = 1'b1;
          inc_pr       = 1'b1;
          w_next_state = S_EXEC;
        end
      end

      S_EXEC: begin
        case (w_op)
          OP_LDA, OP_ADD: begin
            addr_sel = 1'b1;
            mem_rd   = 1'b1;
            if (mem_rdy) begin
              load_acc     = (w_op == OP_LDA);
              add_acc      = (w_op == OP_ADD);
              w_next_state = S_FETCH;
            end
          end
          OP_STA: begin
            addr_sel = 1'b1;
            mem_wr   = 1'b1;
            if (mem_rdy) w_next_state = S_FETCH;
          end
          OP_JMP: begin
            load_ar_2_pr = 1'b1;
            w_next_state = S_FETCH;
          end
          OP_JZ: begin
            // operand byte was already consumed, so a not-taken JZ just falls through
            load_ar_2_pr = zero_flag;
            w_next_state = S_FETCH;
          end
          default: w_next_state = S_FETCH;
        endcase
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: w_next_state = S_RST;
    endcase
  end

`ifdef PCSEQ_ILLEGAL_TRAP_EN
  // IR cannot change while parked in HALT, so the trapping opcode stays visible there
  assign illegal_op = (r_state == S_HALT) && (w_op >= 4'h7);
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: small processor datapath around the DUT, directed sequences
// plus random programs checked against an instruction-level reference interpreter.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_rdy;
  logic [7:0] ir_in;
  logic       zero_flag;
  logic       inc_pr, load_ar_2_pr, addr_sel, mem_rd, mem_wr;
  logic       load_ir, load_ar, load_acc, add_acc, halted;
`ifdef PCSEQ_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .mem_rdy      (mem_rdy),
    .ir_in        (ir_in),
    .zero_flag    (zero_flag),
    .inc_pr       (inc_pr),
    .load_ar_2_pr (load_ar_2_pr),
    .addr_sel     (addr_sel),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .load_ir      (load_ir),
    .load_ar      (load_ar),
    .load_acc     (load_acc),
    .add_acc      (add_acc),
    .halted       (halted)
`ifdef PCSEQ_ILLEGAL_TRAP_EN
    ,
    .illegal_op   (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  // datapath driven by the sequencer strobes; memory is reloaded from prog on reset
  logic [7:0] prog [256];
  logic [7:0] mem  [256];
  logic [7:0] mm   [256];
  logic [7:0] r_pc, r_ar, r_acc;
  wire  [7:0] w_addr  = addr_sel ? r_ar : r_pc;
  wire  [7:0] w_rdata = mem[w_addr];
  assign zero_flag = (r_acc == 8'h00);

  always @(posedge clk) begin
    if (reset) begin
      r_pc  <= 8'h00;
      r_ar  <= 8'h00;
      r_acc <= 8'h00;
      ir_in <= 8'h00;
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
    end else begin
      if (load_ir)  ir_in <= w_rdata;
      if (load_ar)  r_ar  <= w_rdata;
      if (load_acc) r_acc <= w_rdata;
      if (add_acc)  r_acc <= r_acc + w_rdata;
      if (mem_wr && mem_rdy) mem[r_ar] <= r_acc;
      if (inc_pr) r_pc <= r_pc + 8'h01;
      else if (load_ar_2_pr) r_pc <= r_ar;
    end
  end

  wire [9:0] w_outs = {inc_pr, load_ar_2_pr, addr_sel, mem_rd, mem_wr,
                       load_ir, load_ar, load_acc, add_acc, halted};

  localparam logic [9:0] INC  = 10'h200;
  localparam logic [9:0] L2P  = 10'h100;
  localparam logic [9:0] SEL  = 10'h080;
  localparam logic [9:0] RD   = 10'h040;
  localparam logic [9:0] WR   = 10'h020;
  localparam logic [9:0] LIR  = 10'h010;
  localparam logic [9:0] LAR  = 10'h008;
  localparam logic [9:0] LACC = 10'h004;
  localparam logic [9:0] HLTD = 10'h001;
  localparam logic [9:0] NONE = 10'h000;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance one cycle, drive mem_rdy, then compare the whole strobe vector
  task automatic cyc(input string tag, input logic rdy, input logic [9:0] exp);
    @(negedge clk);
    mem_rdy = rdy;
    #2;
    check(tag, 32'(w_outs), 32'(exp));
  endtask

  // returns inside the single RST cycle that follows reset release
  task automatic go_reset();
    @(negedge clk);
    reset   = 1'b1;
    mem_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      mem_rdy = 1'b1;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
  endtask

  // random program: forward-only jumps to instruction starts, data at 0xC0-0xFF, ends in HLT
  logic [7:0] starts [64];
  logic [3:0] ops    [64];

  task automatic gen_prog();
    int addr, r, n;
    logic [3:0] op;
    n = int'($urandom_range(8, 24));
    clear_prog();
    for (int i = 8'hC0; i < 256; i++)
      prog[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    addr = 0;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) op = 4'h6;
      else begin
        r = int'($urandom_range(0, 99));
        if      (r < 10) op = 4'h0;
        else if (r < 25) op = 4'h1;
        else if (r < 40) op = 4'h2;
        else if (r < 60) op = 4'h3;
        else if (r < 68) op = 4'h4;
        else if (r < 82) op = 4'h5;
        else if (r < 92) op = 4'($urandom_range(7, 15));
        else             op = 4'h0;
      end
      starts[i] = 8'(addr);
      ops[i]    = op;
      addr += (op >= 4'h1 && op <= 4'h5) ? 2 : 1;
    end
    for (int i = 0; i < n; i++) begin
      prog[starts[i]] = {ops[i], 4'($urandom)};
      if (ops[i] >= 4'h1 && ops[i] <= 4'h5)
        prog[starts[i] + 8'h01] = (ops[i] == 4'h4 || ops[i] == 4'h5)
                                ? starts[$urandom_range(i + 1, n - 1)]
                                : 8'(8'hC0 + $urandom_range(0, 63));
    end
  endtask

  // instruction-level interpreter: cycle cost per instruction, no notion of FSM states
  task automatic model_run(output int cyc_cnt, output logic [7:0] pc, output logic [7:0] acc,
                           output logic ill);
    logic [7:0] a;
    logic [3:0] op;
    logic       stop;
    for (int i = 0; i < 256; i++) mm[i] = prog[i];
    pc = 8'h00; acc = 8'h00; cyc_cnt = 1; ill = 1'b0; stop = 1'b0;
    for (int n = 0; n < 200 && !stop; n++) begin
      op = mm[pc][7:4];
      pc = pc + 8'h01;
      if (op >= 4'h1 && op <= 4'h5) begin
        a  = mm[pc];
        pc = pc + 8'h01;
        cyc_cnt += 4;
        case (op)
          4'h1:    acc = mm[a];
          4'h2:    mm[a] = acc;
          4'h3:    acc = acc + mm[a];
          4'h4:    pc = a;
          default: if (acc == 8'h00) pc = a;
        endcase
      end else begin
        cyc_cnt += 2;
        if (op == 4'h6) stop = 1'b1;
`ifdef PCSEQ_ILLEGAL_TRAP_EN
        else if (op >= 4'h7) begin
          ill  = 1'b1;
          stop = 1'b1;
        end
`endif
      end
    end
  endtask

  initial begin
    int         m_cyc, cycles, waits, diffs;
    logic [7:0] m_pc, m_acc;
    logic       m_ill, done, req;

    reset   = 1'b1;
    mem_rdy = 1'b0;
    clear_prog();

    // reset while FETCH is waiting on memory
    go_reset();
    #2 check("rst_outputs", 32'(w_outs), 32'(NONE));
    cyc("t1_fetch_wait", 1'b0, RD);
    reset = 1'b1;
    cyc("t1_reset_held", 1'b0, NONE);
    cyc("t1_rst_cycle", 1'b0, NONE);
    reset = 1'b0;
    cyc("t1_fetch_again", 1'b0, RD);

    // LDA 0x20, zero-wait
    clear_prog();
    prog[0] = 8'h10; prog[1] = 8'h20; prog[8'h20] = 8'h5A;
    go_reset();
    cyc("lda_fetch",   1'b1, INC | RD | LIR);
    cyc("lda_decode",  1'b1, NONE);
    cyc("lda_operand", 1'b1, INC | RD | LAR);
    cyc("lda_exec",    1'b1, SEL | RD | LACC);
    cyc("lda_fetch5",  1'b0, RD);
    check("lda_acc", 32'(r_acc), 32'h5A);
    check("lda_pc",  32'(r_pc),  32'h02);

    // JZ taken (ACC is 0 after reset)
    clear_prog();
    prog[0] = 8'h50; prog[1] = 8'h08;
    go_reset();
    cyc("jz1_fetch",   1'b1, INC | RD | LIR);
    cyc("jz1_decode",  1'b1, NONE);
    cyc("jz1_operand", 1'b1, INC | RD | LAR);
    cyc("jz1_exec",    1'b1, L2P);
    cyc("jz1_fetch2",  1'b0, RD);
    check("jz1_pc", 32'(r_pc), 32'h08);

    // JZ not taken after loading a nonzero ACC
    clear_prog();
    prog[0] = 8'h10; prog[1] = 8'h30; prog[8'h30] = 8'h77;
    prog[2] = 8'h50; prog[3] = 8'h08;
    go_reset();
    run_cycles(4);
    cyc("jz0_fetch",   1'b1, INC | RD | LIR);
    cyc("jz0_decode",  1'b1, NONE);
    cyc("jz0_operand", 1'b1, INC | RD | LAR);
    cyc("jz0_exec",    1'b1, NONE);
    cyc("jz0_fetch2",  1'b0, RD);
    check("jz0_pc",  32'(r_pc),  32'h04);
    check("jz0_acc", 32'(r_acc), 32'h77);

    // STA with three wait cycles in EXEC
    clear_prog();
    prog[0] = 8'h20; prog[1] = 8'h40; prog[8'h40] = 8'hEE;
    go_reset();
    cyc("sta_fetch",   1'b1, INC | RD | LIR);
    cyc("sta_decode",  1'b1, NONE);
    cyc("sta_operand", 1'b1, INC | RD | LAR);
    for (int i = 0; i < 3; i++) cyc("sta_exec_wait", 1'b0, SEL | WR);
    cyc("sta_exec_done", 1'b1, SEL | WR);
    cyc("sta_fetch2",    1'b0, RD);
    check("sta_mem", 32'(mem[8'h40]), 32'h00);

    // HLT holds for 20 cycles whatever mem_rdy does, reset releases it
    clear_prog();
    prog[0] = 8'h60;
    go_reset();
    cyc("hlt_fetch",  1'b1, INC | RD | LIR);
    cyc("hlt_decode", 1'b1, NONE);
    for (int i = 0; i < 20; i++) begin
      cyc("hlt_hold", 1'($urandom_range(0, 1)), HLTD);
`ifdef PCSEQ_ILLEGAL_TRAP_EN
      check("hlt_no_illegal", 32'(illegal_op), 32'h0);
`endif
    end
    go_reset();
    #2 check("hlt_cleared", 32'(w_outs), 32'(NONE));

    // opcode 0xA0
    clear_prog();
    prog[0] = 8'hA0;
    go_reset();
    cyc("ill_fetch",  1'b1, INC | RD | LIR);
    cyc("ill_decode", 1'b1, NONE);
`ifdef PCSEQ_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      cyc("ill_halt", 1'b1, HLTD);
      check("ill_flag", 32'(illegal_op), 32'h1);
    end
    go_reset();
    #2 check("ill_reset_outs", 32'(w_outs), 32'(NONE));
    check("ill_reset_flag", 32'(illegal_op), 32'h0);
`else
    cyc("ill_nop_fetch", 1'b0, RD);
    check("ill_nop_pc", 32'(r_pc), 32'h01);
`endif

    // random programs with random wait states and stray mem_rdy
    for (int p = 0; p < 25; p++) begin
      gen_prog();
      model_run(m_cyc, m_pc, m_acc, m_ill);
      go_reset();
      cycles = 0; waits = 0; done = 1'b0;
      for (int k = 0; k < 3000 && !done; k++) begin
        #1;
        req     = mem_rd | mem_wr;
        mem_rdy = req ? 1'($urandom_range(0, 99) < 65) : 1'($urandom_range(0, 1));
        #1;
        if (halted) done = 1'b1;
        else begin
          check("excl_pc_strobes",  32'(inc_pr & load_ar_2_pr), 32'h0);
          check("excl_mem_strobes", 32'(mem_rd & mem_wr),       32'h0);
          if (req && !mem_rdy) waits++;
          cycles++;
          @(negedge clk);
        end
      end
      check("rand_reached_halt", 32'(done), 32'h1);
      check("rand_cycles", 32'(cycles), 32'(m_cyc + waits));
      check("rand_acc", 32'(r_acc), 32'(m_acc));
      check("rand_pc",  32'(r_pc),  32'(m_pc));
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) diffs++;
      check("rand_mem_diffs", 32'(diffs), 32'h0);
`ifdef PCSEQ_ILLEGAL_TRAP_EN
      check("rand_illegal_op", 32'(illegal_op), 32'(m_ill));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
